// File: rtl/uart_pkg.sv
// uart_pkg: encodings and sizing shared by the UART transmitter and receiver.
// The PAR state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_TICKS_PER_BIT = 16;
    localparam int unsigned UART_HALF_TICKS    = UART_TICKS_PER_BIT / 2;
    localparam int unsigned UART_WORD_SZ       = 8;

    // Counter width that stays at least one bit wide for tiny ranges
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned UART_TICK_CW = cnt_w(UART_TICKS_PER_BIT);
    localparam int unsigned UART_BIT_CW  = cnt_w(UART_WORD_SZ);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        BIT   = 3'b011,
        STOP  = 3'b010,
        PAR   = 3'b100
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        BIT   = 2'b11,
        STOP  = 2'b10
    } uart_state_e;
`endif

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side byte handshake and sticky error flags of the receiver.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned WORD_SZ = UART_WORD_SZ
);

    logic [WORD_SZ-1:0] dout;
    logic               data_valid;
    logic               host_rd;
    logic               frame_err;
    logic               overrun;
    logic               parity_err;

    modport slave (
        output dout, data_valid, frame_err, overrun, parity_err,
        input  host_rd
    );

    modport master (
        input  dout, data_valid, frame_err, overrun, parity_err,
        output host_rd
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: STAGES-deep synchroniser for an asynchronous input, resets to 1 (idle line).
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_b,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) sync_q <= '1;
        else          sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, TICKS_PER_BIT clocks per bit, sticky error flags.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BIT = UART_TICKS_PER_BIT,
    parameter int unsigned WORD_SZ       = UART_WORD_SZ,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic      clk,
    input  logic      reset_b,
    input  logic      serin,
    uart_rx_if.slave  bus
);

    localparam int unsigned TICK_CW = cnt_w(TICKS_PER_BIT);
    localparam int unsigned BIT_CW  = cnt_w(WORD_SZ);
    localparam logic [TICK_CW-1:0] TICK_LAST = TICK_CW'(TICKS_PER_BIT - 1);
    localparam logic [TICK_CW-1:0] TICK_MID  = TICK_CW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(WORD_SZ - 1);

    logic rx_s;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d       (serin),
        .q       (rx_s)
    );

    uart_state_e        state_q, state_d;
    logic [TICK_CW-1:0] tick_q, tick_d;
    logic [BIT_CW-1:0]  bit_q, bit_d;
    logic [WORD_SZ-1:0] shift_q, shift_d;
    logic [WORD_SZ-1:0] dout_q, dout_d;
    logic               dv_q, dv_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic               perr_q, perr_d;
    logic               par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        dv_d    = dv_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
        par_bad_d = par_bad_q;
`endif

        // Host clear first so any flag set below in the same cycle wins
        if (bus.host_rd) begin
            dv_d   = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b0;
`endif
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick_q == TICK_MID) begin
                    if (!rx_s) begin
                        state_d = BIT;
                        tick_d  = '0;
                        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            BIT: begin
                if (tick_q == TICK_LAST) begin
                    shift_d = {rx_s, shift_q[WORD_SZ-1:1]};
                    tick_d  = '0;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PAR: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = STOP;
                    if (rx_s != ^shift_q) begin
                        perr_d    = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        ferr_d = ferr_d;
`endif
                    end else if (!dv_q || bus.host_rd) begin
                        dout_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.data_valid = dv_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames driven onto serin with hand-computed receive timing and results.
module tb_uart_rx;

    localparam int TPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = TPB * FB;
    // serin low after edge n0 -> rx_s low seen by IDLE at edge n0+3 (T); stop sampled at T+TPB/2+(FB-1)*TPB
    localparam int DONE = 3 + TPB / 2 + TPB * (FB - 1);

    logic clk = 1'b0;
    logic reset_b;
    logic serin;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n0;
    int   n1;

    uart_rx_if #(.WORD_SZ(8)) bus ();

    uart_rx #(
        .TICKS_PER_BIT (TPB),
        .WORD_SZ       (8),
        .SYNC_STAGES   (2)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .serin   (serin),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rd();
        bus.host_rd = 1'b1;
        tick(1);
        bus.host_rd = 1'b0;
    endtask

    // Must be called #1 after a clock edge; returns at the same phase
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serin = 1'b0;
        tick(TPB);
        for (int i = 0; i < 8; i++) begin
            serin = b[i];
            tick(TPB);
        end
`ifdef UART_RX_PARITY_EN
        serin = ^b;
        tick(TPB);
`endif
        serin = stop_bit;
        tick(TPB);
        serin = 1'b1;
    endtask

    initial begin
        reset_b     = 1'b0;
        serin       = 1'b1;
        bus.host_rd = 1'b0;
        tick(4);
        reset_b = 1'b1;
        tick(3);

        check_eq("rst_dout", bus.dout, 32'h00);
        check_eq("rst_dv", bus.data_valid, 0);
        check_eq("rst_ferr", bus.frame_err, 0);
        check_eq("rst_ovr", bus.overrun, 0);
        check_eq("rst_perr", bus.parity_err, 0);

        // 0xA5 with exact data_valid rise cycle
        n0 = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_until(n0 + DONE - 1);
                check_eq("a5_dv_early", bus.data_valid, 0);
                tick(1);
                check_eq("a5_dv_rise", bus.data_valid, 1);
            end
        join
        check_eq("a5_dout", bus.dout, 32'hA5);
        check_eq("a5_ferr", bus.frame_err, 0);
        pulse_rd();
        check_eq("a5_dv_clr", bus.data_valid, 0);

        // 6-cycle glitch on the idle line
        serin = 1'b0;
        tick(6);
        serin = 1'b1;
        tick(40);
        check_eq("glitch_dv", bus.data_valid, 0);
        check_eq("glitch_ferr", bus.frame_err, 0);

        // Stop bit forced low
        send_frame(8'h3C, 1'b0);
        tick(30);
        check_eq("ferr_set", bus.frame_err, 1);
        check_eq("ferr_dv", bus.data_valid, 0);
        check_eq("ferr_dout", bus.dout, 32'hA5);
        pulse_rd();
        check_eq("ferr_clr", bus.frame_err, 0);

        // Overrun: second byte dropped
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(4);
        check_eq("ovr_dout", bus.dout, 32'h11);
        check_eq("ovr_set", bus.overrun, 1);
        check_eq("ovr_dv", bus.data_valid, 1);
        pulse_rd();
        check_eq("ovr_clr", bus.overrun, 0);
        check_eq("ovr_dv_clr", bus.data_valid, 0);

        // host_rd in the second byte's completion cycle: new byte taken, set wins
        send_frame(8'h11, 1'b1);
        n1 = cyc;
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait_until(n1 + DONE - 1);
                pulse_rd();
            end
        join
        tick(2);
        check_eq("rdsame_dout", bus.dout, 32'h22);
        check_eq("rdsame_ovr", bus.overrun, 0);
        check_eq("rdsame_dv", bus.data_valid, 1);
        pulse_rd();

        // Reset during bit 4; 0xF0 keeps the line high after bit 3 so no false start follows
        n0 = cyc;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_until(n0 + 3 + TPB / 2 + TPB * 4 + 4);
                reset_b = 1'b0;
                tick(1);
                reset_b = 1'b1;
            end
        join
        tick(30);
        check_eq("mrst_dv", bus.data_valid, 0);
        check_eq("mrst_dout", bus.dout, 32'h00);
        check_eq("mrst_ferr", bus.frame_err, 0);
        send_frame(8'h5A, 1'b1);
        tick(2);
        check_eq("mrst_5a_dout", bus.dout, 32'h5A);
        check_eq("mrst_5a_dv", bus.data_valid, 1);
        check_eq("mrst_5a_ferr", bus.frame_err, 0);
        check_eq("mrst_5a_ovr", bus.overrun, 0);
        pulse_rd();

        // Back-to-back frames, host reads each
        n0 = cyc;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h81, 1'b1);
            end
            begin
                wait_until(n0 + DONE);
                check_eq("b2b0_dout", bus.dout, 32'h00);
                check_eq("b2b0_dv", bus.data_valid, 1);
                pulse_rd();
                wait_until(n0 + FRAME_CYC + DONE);
                check_eq("b2b1_dout", bus.dout, 32'hFF);
                check_eq("b2b1_dv", bus.data_valid, 1);
                pulse_rd();
                wait_until(n0 + 2 * FRAME_CYC + DONE);
                check_eq("b2b2_dout", bus.dout, 32'h81);
                check_eq("b2b2_dv", bus.data_valid, 1);
                check_eq("b2b_ferr", bus.frame_err, 0);
                check_eq("b2b_ovr", bus.overrun, 0);
                check_eq("b2b_perr", bus.parity_err, 0);
                pulse_rd();
            end
        join
        tick(4);
        check_eq("b2b_dv_end", bus.data_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
